// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: fully pipelined signed adder tree with a valid sideband and
// an optional multi-beat accumulate stage.
//
// Pipeline: operand register (sign-extended) -> LEVELS tree levels -> accumulator.
// A beat sampled on rising edge A shows up on out_valid/res after edge A+LEVELS+1.
// The odd element of a level is added to zero, so it passes through unchanged.
module adder_tree_pipe #(
  parameter int INPUT_NUM = 9,
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = WIDTH + $clog2(INPUT_NUM) + 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               acc_en,
  input  logic                               in_last,
  input  logic [INPUT_NUM-1:0][WIDTH-1:0]    indata,
  output logic                               out_valid,
  output logic signed [OUT_WIDTH-1:0]        res
);

  localparam int LEVELS = $clog2(INPUT_NUM);

  // Element count of tree level k (level 0 is the operand register).
  function automatic int level_cnt(input int k);
    int n;
    n = INPUT_NUM;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // Position of level k's first element if all levels were laid end to end.
  function automatic int level_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += level_cnt(j);
    return o;
  endfunction

  // Tree levels 1..LEVELS packed into one array; level k starts at level_off(k)-INPUT_NUM.
  localparam int NREG = level_off(LEVELS + 1) - INPUT_NUM;

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic last;
  } side_t;

  logic signed [OUT_WIDTH-1:0] ext  [INPUT_NUM];
  logic signed [OUT_WIDTH-1:0] node [NREG];
  side_t                       side [LEVELS+1];

  logic signed [OUT_WIDTH-1:0] tree_sum;
  side_t                       tree_side;
  logic signed [OUT_WIDTH-1:0] acc;
  logic                        group_open;

  generate
    for (genvar i = 0; i < INPUT_NUM; i++) begin : g_ext
      // Register each operand sign-extended to the full result width.
      // NOTE: datapath registers carry no reset; only the valid sideband must be
      // clean after reset, and leaving data unreset keeps the adders' flops simple.
      always_ff @(posedge clk)
        ext[i] <= {{(OUT_WIDTH - WIDTH){indata[i][WIDTH-1]}}, indata[i]};
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int PCNT = level_cnt(k - 1);
      localparam int POFF = level_off(k - 1) - INPUT_NUM;
      localparam int COFF = level_off(k) - INPUT_NUM;

      for (genvar i = 0; i < level_cnt(k); i++) begin : g_node
        logic signed [OUT_WIDTH-1:0] left;
        logic signed [OUT_WIDTH-1:0] right;

        if (k == 1) begin : g_left0
          assign left = ext[2*i];
        end else begin : g_leftn
          assign left = node[POFF + 2*i];
        end

        if (2*i + 1 < PCNT) begin : g_pair
          if (k == 1) begin : g_right0
            assign right = ext[2*i + 1];
          end else begin : g_rightn
            assign right = node[POFF + 2*i + 1];
          end
        end else begin : g_odd
          assign right = '0;
        end

        // Register the pairwise sum (or the unpaired element) for this level.
        always_ff @(posedge clk)
          node[COFF + i] <= left + right;
      end
    end
  endgenerate

  assign tree_sum  = node[NREG-1];
  assign tree_side = side[LEVELS];

  // Sideband shift register, kept in lockstep with the operand and tree stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      side <= '{default: '0};
    end else begin
      side[0] <= '{valid: in_valid, acc_en: acc_en, last: in_last};
      for (int k = 1; k <= LEVELS; k++) side[k] <= side[k-1];
    end
  end

  // Accumulator / output stage: pass a plain beat through, or fold a group of beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      res        <= '0;
      acc        <= '0;
      group_open <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_side.valid) begin
        if (!tree_side.acc_en) begin
          res        <= tree_sum;
          out_valid  <= 1'b1;
          group_open <= 1'b0;
        end else if (!tree_side.last) begin
          acc        <= group_open ? acc + tree_sum : tree_sum;
          group_open <= 1'b1;
        end else begin
          res        <= group_open ? acc + tree_sum : tree_sum;
          out_valid  <= 1'b1;
          group_open <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed scenarios plus random traffic,
// scored against a beat-level reference model of the sum/accumulate rules.
module tb_adder_tree_pipe;

  localparam int INPUT_NUM = 9;
  localparam int WIDTH     = 32;
  localparam int OUT_WIDTH = WIDTH + $clog2(INPUT_NUM) + 8;
  localparam int LEVELS    = $clog2(INPUT_NUM);
  localparam int DRAIN     = LEVELS + 4;

  typedef logic [INPUT_NUM-1:0][WIDTH-1:0] din_t;
  typedef logic signed [OUT_WIDTH-1:0]     sum_t;
  typedef struct { int cyc; sum_t val; } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic acc_en = 1'b0;
  logic in_last = 1'b0;
  din_t indata = '0;
  logic out_valid;
  sum_t res;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  item_t exp_q[$];
  item_t obs_q[$];

  // Reference model state: one open group at most.
  bit   m_open = 1'b0;
  sum_t m_acc  = '0;

  adder_tree_pipe #(
    .INPUT_NUM(INPUT_NUM),
    .WIDTH    (WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .acc_en   (acc_en),
    .in_last  (in_last),
    .indata   (indata),
    .out_valid(out_valid),
    .res      (res)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp accepts and output pulses.
  always @(posedge clk) cyc++;

  // Record every output pulse, sampled away from the active edge.
  always @(negedge clk)
    if (out_valid === 1'b1) obs_q.push_back('{cyc: cyc, val: res});

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1);
  end

  // Apply the specification's rules to one accepted beat; expected output appears
  // LEVELS+1 edges after the accepting edge.
  task automatic model_beat(input din_t d, input bit a, input bit l, input int acc_cyc);
    sum_t t;
    t = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      logic signed [WIDTH-1:0] op;
      op = d[i];
      t  = t + sum_t'(op);
    end
    if (!a) begin
      exp_q.push_back('{cyc: acc_cyc + LEVELS + 1, val: t});
      m_open = 1'b0;
    end else if (!l) begin
      m_acc  = m_open ? m_acc + t : t;
      m_open = 1'b1;
    end else begin
      exp_q.push_back('{cyc: acc_cyc + LEVELS + 1, val: m_open ? m_acc + t : t});
      m_open = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_open = 1'b0;
    m_acc  = '0;
    exp_q.delete();
  endtask

  // Present one cycle of stimulus; the following rising edge samples it.
  task automatic drive(input bit v, input din_t d, input bit a, input bit l);
    @(negedge clk);
    in_valid = v;
    indata   = d;
    acc_en   = a;
    in_last  = l;
    if (v && !rst) model_beat(d, a, l, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    din_t d;
    for (int i = 0; i < INPUT_NUM; i++) d[i] = WIDTH'($urandom);
    rst = 1'b1;
    repeat (3) drive(1'b1, d, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset.out_valid: got %b want 0", out_valid);
    else passes++;
    checks++;
    if (res !== '0) $display("FAIL reset.res: got %0d want 0", res);
    else passes++;
    idle(DRAIN);
    checks++;
    if (obs_q.size() != 0) $display("FAIL reset.no_pulse: got %0d pulses want 0", obs_q.size());
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single_beat();
    din_t d;
    d = '0;
    d[0] = WIDTH'(-4);
    d[1] = WIDTH'(2);
    d[INPUT_NUM-1] = WIDTH'(1);
    drive(1'b1, d, 1'b0, 1'b0);
    idle(DRAIN);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL single.count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL single.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    checks++;
    if (res !== {OUT_WIDTH{1'b1}}) $display("FAIL single.all_ones: got %0d want -1", res);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_accumulate();
    din_t d;
    for (int i = 0; i < INPUT_NUM; i++) d[i] = WIDTH'(1);
    drive(1'b1, d, 1'b1, 1'b0);
    drive(1'b1, d, 1'b1, 1'b0);
    drive(1'b1, d, 1'b1, 1'b1);
    idle(DRAIN);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL accumulate.count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL accumulate.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    checks++;
    if (res !== sum_t'(3 * INPUT_NUM)) $display("FAIL accumulate.total: got %0d want %0d", res, 3 * INPUT_NUM);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_extremes();
    din_t dmax;
    din_t dmin;
    sum_t want_min;
    want_min = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      dmax[i] = {1'b0, {(WIDTH-1){1'b1}}};
      dmin[i] = {1'b1, {(WIDTH-1){1'b0}}};
      want_min = want_min - (sum_t'(1) <<< (WIDTH - 1));
    end
    drive(1'b1, dmax, 1'b0, 1'b0);
    drive(1'b1, dmin, 1'b0, 1'b0);
    idle(DRAIN);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL extremes.count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL extremes.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    checks++;
    if (res !== want_min) $display("FAIL extremes.min: got %0d want %0d", res, want_min);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    din_t d;
    for (int b = 0; b < 8; b++) begin
      d = '0;
      d[0] = WIDTH'(b);
      drive(1'b1, d, 1'b0, 1'b0);
    end
    idle(DRAIN);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL stream.count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL stream.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_group_abort();
    din_t d;
    d = '0; d[0] = WIDTH'(5);
    drive(1'b1, d, 1'b1, 1'b0);
    d = '0; d[0] = WIDTH'(3);
    drive(1'b1, d, 1'b0, 1'b0);
    d = '0; d[0] = WIDTH'(7);
    drive(1'b1, d, 1'b1, 1'b1);
    idle(DRAIN);
    checks++;
    if (obs_q.size() != 2) $display("FAIL abort.count: got %0d want 2", obs_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL abort.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    checks++;
    if (res !== sum_t'(7)) $display("FAIL abort.last: got %0d want 7", res);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    din_t d;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < INPUT_NUM; i++) d[i] = WIDTH'($urandom);
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    idle(DRAIN);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL random.count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL random.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    din_t d;
    for (int b = 1; b <= 3; b++) begin
      d = '0;
      d[0] = WIDTH'(10 * b);
      drive(1'b1, d, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(DRAIN);
    checks++;
    if (obs_q.size() != 0) $display("FAIL reset_mid.flushed: got %0d pulses want 0", obs_q.size());
    else passes++;
    checks++;
    if (res !== '0) $display("FAIL reset_mid.res: got %0d want 0", res);
    else passes++;
    obs_q.delete();
    for (int i = 0; i < INPUT_NUM; i++) d[i] = WIDTH'($urandom);
    drive(1'b1, d, 1'b0, 1'b0);
    idle(DRAIN);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL reset_mid.count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL reset_mid.beat%0d: got cyc %0d res %0d want cyc %0d res %0d", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_accumulate();
    test_extremes();
    test_back_to_back();
    test_group_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, fully pipelined signed adder tree with a valid sideband and an optional multi-beat accumulate mode. It reduces INPUT_NUM signed operands per beat to one sum, at a throughput of one beat per cycle. It sits behind the convolution multiplier array: one beat is one kernel window (e.g. 3x3 = 9 products). In accumulate mode, consecutive beats (input channels) are summed into a single output.

## Interface
Parameters:
- INPUT_NUM, 9, operands per beat; must be >= 2
- WIDTH, 32, signed operand width
- OUT_WIDTH, WIDTH + $clog2(INPUT_NUM) + 8, signed result/accumulator width; must be >= WIDTH + $clog2(INPUT_NUM)
- LEVELS (localparam), $clog2(INPUT_NUM), number of tree register stages

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat present on indata this cycle
- acc_en  in  1  beat belongs to an accumulation group; sampled with in_valid
- in_last  in  1  last beat of group; meaningful only when in_valid=1 and acc_en=1
- indata  in  [INPUT_NUM-1:0][WIDTH-1:0]  signed operands
- out_valid  out  1  one-cycle pulse; res is valid this cycle
- res  out  OUT_WIDTH  signed sum or accumulated sum

## Operation
- Operands are sign-extended to OUT_WIDTH at the input.
- Tree:
  - Level k pairs adjacent elements of level k-1 and registers each sum.
  - When a level has an odd element count, the unpaired last element is registered unchanged.
  - Every level is registered, so LEVELS register stages in total.
- Sideband: in_valid, acc_en and in_last travel down a shift register in lockstep with the data. A beat with in_valid=0 never affects the accumulator or the outputs.
- There is no backpressure; a new beat is accepted every cycle.
- Accumulator stage (one register stage after the tree; internal group_open flag, acc register). When the tree output T is valid:
  - acc_en=0: res<=T, out_valid<=1; group_open<=0 (any open group is discarded).
  - acc_en=1, in_last=0: acc<= (group_open ? acc+T : T); group_open<=1; out_valid<=0.
  - acc_en=1, in_last=1: res<= (group_open ? acc+T : T); out_valid<=1; group_open<=0.
  - A single-beat group (acc_en=1, in_last=1, no open group) therefore outputs T.
- Arithmetic is two's complement modulo 2^OUT_WIDTH; the sum wraps on overflow, with no saturation and no flag. A single beat cannot overflow, given the OUT_WIDTH constraint.
- res holds its last value between out_valid pulses.

## Timing
- Reset values: out_valid=0, res=0, acc=0, group_open=0, all pipeline valid bits 0. Pipeline data registers are don't-care.
- Latency: out_valid pulses LEVELS+1 cycles after the rising edge that sampled the producing beat (the last beat in accumulate mode). For INPUT_NUM=9 this is 5 cycles.
- Throughput: N back-to-back acc_en=0 beats give N consecutive out_valid pulses, in order.
- in_valid is ignored while rst=1.
- Reset mid-operation: all in-flight beats and any open group are dropped. The first out_valid after rst falls comes only from a beat accepted after reset.
- Output registers are driven by flops only; there is no combinational path from input to output.

## Test plan
- Single beat, acc_en=0: indata[0]=-4, indata[1]=2, indata[8]=1, rest 0 -> res=-1 (all ones, OUT_WIDTH bits), out_valid high exactly 5 cycles after accept, for one cycle.
- Accumulate: 3 beats of all-ones operands, acc_en=1, in_last on beat 3 -> exactly one out_valid, res=27; no pulse for beats 1-2.
- Extremes: all operands 0x7FFFFFFF -> res=19327352823; all operands 0x80000000 -> res=-19327352832. Both via acc_en=0, with no wrap.
- Streaming: 8 back-to-back beats with indata[0]=i (i=0..7), acc_en=0 -> 8 consecutive out_valid cycles, res=0..7 in order. Repeat with INPUT_NUM=4 and INPUT_NUM=16 builds, checking latency LEVELS+1.
- Group abort: acc_en=1 beat (sum 5), then acc_en=0 beat (sum 3), then acc_en=1 in_last beat (sum 7) -> outputs res=3, then res=7. The 5 is discarded.
- Reset mid-pipeline: accept 3 beats, assert rst for 1 cycle after 2 cycles -> no out_valid from those beats, res=0. A beat after reset produces correct res at nominal latency.
